// File: rtl/mult_add_pkg.sv
// Shared definitions for the multiply-add datapath and its inverse.
// Holds the common widths, the saturation limits and the state encoding
// of the sequential inverse.
package mult_add_pkg;

    localparam int MA_AW = 16;
    localparam int MA_PW = 32;

    localparam logic [MA_AW-1:0] MA_QMAX = 16'h7FFF;
    localparam logic [MA_AW-1:0] MA_QMIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } ma_state_e;

endpackage

// File: rtl/mult_add_inverse_udiv_step.sv
// One radix-2 restoring division step on unsigned operands.
// Shifts the partial remainder left by one and brings in the next dividend bit.
// It then subtracts the divisor when it fits and reports the quotient bit.
// The caller keeps rem_in < divisor, so the shifted value fits in W+1 bits.
// The remainder after the subtract fits in W bits.
module udiv_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] divisor,
    input  logic         bit_in,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0] shifted;

    // Shift, compare and conditionally subtract for a single quotient bit
    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? (shifted[W-1:0] - divisor) : shifted[W-1:0];
    end

endmodule

// File: rtl/mult_add_inverse.sv
// Sequential inverse of the multiply-add: recovers a = (p - c) / b,
// or (c - p) / b when subtract is set.
// It also reports the remainder and the overflow and divide-by-zero flags.
// Division is restoring shift-subtract, one quotient bit per clock.
// Optional feature: define MULTADD_INV_ROUND_EN to round the quotient to
// nearest, with halves rounded away from zero, instead of truncating.
module mult_add_inverse
    import mult_add_pkg::*;
#(
    parameter int AW = MA_AW,
    parameter int PW = MA_PW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          subtract,
    input  logic [PW-1:0] p,
    input  logic [PW-1:0] c,
    input  logic [AW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] a,
    output logic [AW-1:0] rem,
    output logic          ovf,
    output logic          div0
);

    localparam int CW = $clog2(PW + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(PW);
    localparam logic [AW-1:0] QMAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] QMIN = {1'b1, {(AW-1){1'b0}}};

    ma_state_e     state;
    logic [PW-1:0] p_r;
    logic [PW-1:0] c_r;
    logic [AW-1:0] b_r;
    logic          sub_r;
    logic          sign_q;
    logic          sign_r;
    logic          b_zero;
    logic [PW:0]   dshift;
    logic [PW:0]   quo;
    logic [AW-1:0] prem;
    logic [CW-1:0] cnt;

    logic [PW:0]   d_full;
    logic          d_neg;
    logic [PW:0]   d_mag;
    logic [AW-1:0] b_mag;

    logic [AW-1:0] step_rem;
    logic          step_q;

    logic          round_up;
    logic [PW+1:0] q_fix;
    logic [AW-1:0] r_mag_fix;
    logic          r_neg_fix;
    logic [PW+1:0] q_limit;
    logic          ovf_fix;
    logic [AW-1:0] a_fix;
    logic [AW-1:0] rem_fix;

    // Form the 33-bit signed dividend from the captured operands and take
    // the magnitudes of the dividend and divisor (0x8000 gives 32768)
    always_comb begin
        if (sub_r) begin
            d_full = {c_r[PW-1], c_r} - {p_r[PW-1], p_r};
        end else begin
            d_full = {p_r[PW-1], p_r} - {c_r[PW-1], c_r};
        end
        d_neg = d_full[PW];
        d_mag = d_neg ? -d_full : d_full;
        b_mag = b_r[AW-1] ? -b_r : b_r;
    end

    udiv_step #(
        .W(AW)
    ) u_step (
        .rem_in  (prem),
        .divisor (b_mag),
        .bit_in  (dshift[PW]),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Apply rounding, the signs and saturation to the finished magnitudes;
    // the remainder is dropped to zero whenever the quotient saturates
    always_comb begin
`ifdef MULTADD_INV_ROUND_EN
        round_up = ({prem, 1'b0} >= {1'b0, b_mag});
`else
        round_up = 1'b0;
`endif
        q_fix     = {1'b0, quo} + {{(PW+1){1'b0}}, round_up};
        r_mag_fix = round_up ? (b_mag - prem) : prem;
        r_neg_fix = round_up ? ~sign_r : sign_r;
        if (sign_q) begin
            q_limit = {{(PW+2-AW){1'b0}}, 1'b1, {(AW-1){1'b0}}};
        end else begin
            q_limit = {{(PW+3-AW){1'b0}}, {(AW-1){1'b1}}};
        end
        ovf_fix = (q_fix > q_limit);
        if (ovf_fix) begin
            a_fix   = sign_q ? QMIN : QMAX;
            rem_fix = '0;
        end else begin
            a_fix   = sign_q ? -q_fix[AW-1:0] : q_fix[AW-1:0];
            rem_fix = r_neg_fix ? -r_mag_fix : r_mag_fix;
        end
    end

    // Control FSM with the datapath registers and registered outputs; a
    // start is refused while done is high, so the next operation begins
    // on the cycle after done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            p_r    <= '0;
            c_r    <= '0;
            b_r    <= '0;
            sub_r  <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            b_zero <= 1'b0;
            dshift <= '0;
            quo    <= '0;
            prem   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            a      <= '0;
            rem    <= '0;
            ovf    <= 1'b0;
            div0   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        p_r   <= p;
                        c_r   <= c;
                        b_r   <= b;
                        sub_r <= subtract;
                        busy  <= 1'b1;
                        state <= PREP;
                    end
                end
                PREP: begin
                    sign_q <= d_neg ^ b_r[AW-1];
                    sign_r <= d_neg;
                    b_zero <= (b_r == '0);
                    dshift <= d_mag;
                    quo    <= '0;
                    prem   <= '0;
                    cnt    <= '0;
                    state  <= (b_r == '0) ? FIX : ITER;
                end
                ITER: begin
                    prem   <= step_rem;
                    dshift <= {dshift[PW-1:0], 1'b0};
                    quo    <= {quo[PW-1:0], step_q};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (b_zero) begin
                        a    <= sign_r ? QMIN : QMAX;
                        rem  <= '0;
                        ovf  <= 1'b1;
                        div0 <= 1'b1;
                    end else begin
                        a    <= a_fix;
                        rem  <= rem_fix;
                        ovf  <= ovf_fix;
                        div0 <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_add_inverse.sv
// Directed testbench for mult_add_inverse.
// Each operation checks the quotient, remainder, flags and done latency against hand-computed values.
// Also covers abort by reset, ignored starts and back-to-back throughput.
module tb_mult_add_inverse;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        subtract;
    logic [31:0] p;
    logic [31:0] c;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] a;
    logic [15:0] rem;
    logic        ovf;
    logic        div0;

    int checks = 0;
    int errors = 0;
    int lat;
    int gap;
    logic saw_done;

    mult_add_inverse dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .subtract (subtract),
        .p        (p),
        .c        (c),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .a        (a),
        .rem      (rem),
        .ovf      (ovf),
        .div0     (div0)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one cycle; returns at the negedge after the capture edge
    task automatic applyStimulus(input logic [31:0] pv, input logic [31:0] cv,
                                 input logic [15:0] bv, input logic sv);
        @(negedge clk);
        p = pv; c = cv; b = bv; subtract = sv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count cycles (relative to the start cycle) until done, with a bound
    task automatic waitDone(input int first, output int cyc);
        cyc = first;
        while (!done && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic runOp(input string tag, input logic [31:0] pv, input logic [31:0] cv,
                         input logic [15:0] bv, input logic sv,
                         input logic [15:0] ea, input logic [15:0] er,
                         input logic eo, input logic ez, input int elat);
        int l;
        applyStimulus(pv, cv, bv, sv);
        checkOutput({tag, ".busy"}, 64'(busy), 64'd1);
        waitDone(1, l);
        checkOutput({tag, ".lat"}, 64'(l), 64'(elat));
        checkOutput({tag, ".a"}, 64'(a), 64'(ea));
        checkOutput({tag, ".rem"}, 64'(rem), 64'(er));
        checkOutput({tag, ".ovf"}, 64'(ovf), 64'(eo));
        checkOutput({tag, ".div0"}, 64'(div0), 64'(ez));
        checkOutput({tag, ".busyatdone"}, 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput({tag, ".donepulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; subtract = 1'b0;
        p = '0; c = '0; b = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset.a", 64'(a), 64'd0);
        checkOutput("reset.rem", 64'(rem), 64'd0);
        checkOutput("reset.flags", 64'({busy, done, ovf, div0}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed operations");
        runOp("exact", 32'h68FF6000, 32'h4FFFFFFF, 16'h4FFF, 1'b0, 16'h4FFF, 16'h0000, 1'b0, 1'b0, 36);
        runOp("neg16", 32'hFFFC0000, 32'h0, 16'h4000, 1'b0, 16'hFFF0, 16'h0000, 1'b0, 1'b0, 36);
`ifdef MULTADD_INV_ROUND_EN
        runOp("m7div2", 32'hFFFFFFF9, 32'h0, 16'h0002, 1'b0, 16'hFFFC, 16'h0001, 1'b0, 1'b0, 36);
`else
        runOp("m7div2", 32'hFFFFFFF9, 32'h0, 16'h0002, 1'b0, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 36);
`endif
        runOp("satpos", 32'h40000000, 32'h0, 16'h0001, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 36);
        runOp("divzero", 32'h40000000, 32'h0, 16'h0000, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 1'b1, 3);
        runOp("divzeroneg", 32'hFFFFFFFF, 32'h0, 16'h0000, 1'b0, 16'h8000, 16'h0000, 1'b1, 1'b1, 3);
        runOp("minexact", 32'hFFFF8000, 32'h0, 16'h0001, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0, 36);
        runOp("justover", 32'h00008000, 32'h0, 16'h0001, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 36);
        runOp("bmin", 32'h40000000, 32'h0, 16'h8000, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0, 36);
        runOp("rem2", 32'd100, 32'h0, 16'd7, 1'b0, 16'h000E, 16'h0002, 1'b0, 1'b0, 36);
        runOp("wide33", 32'h80000000, 32'h7FFFFFFF, 16'hFFFF, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 36);

        $display("[TB] subtract with a start while busy");
        applyStimulus(32'd0, 32'd100, 16'hFFF6, 1'b1);
        p = 32'd1000; c = 32'd0; b = 16'd1; subtract = 1'b0; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        waitDone(4, lat);
        checkOutput("sub.lat", 64'(lat), 64'd36);
        checkOutput("sub.a", 64'(a), 64'hFFF6);
        checkOutput("sub.rem", 64'(rem), 64'h0);
        checkOutput("sub.ovf", 64'(ovf), 64'h0);
        @(negedge clk);
        checkOutput("sub.noqueue", 64'(busy), 64'd0);

        $display("[TB] start held high");
        p = 32'h68FF6000; c = 32'h4FFFFFFF; b = 16'h4FFF; subtract = 1'b0; start = 1'b1;
        waitDone(0, lat);
        @(negedge clk);
        gap = 1;
        while (!done && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        checkOutput("b2b.gap", 64'(gap), 64'd37);
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("[TB] reset during an operation");
        applyStimulus(32'h68FF6000, 32'h4FFFFFFF, 16'h4FFF, 1'b0);
        repeat (18) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("abort.a", 64'(a), 64'd0);
        checkOutput("abort.rem", 64'(rem), 64'd0);
        checkOutput("abort.flags", 64'({busy, done, ovf, div0}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checkOutput("abort.nodone", 64'(saw_done), 64'd0);
        runOp("afterabort", 32'hFFFC0000, 32'h0, 16'h4000, 1'b0, 16'hFFF0, 16'h0000, 1'b0, 1'b0, 36);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
